// File: rtl/frame_uart_streamer_if.sv
// Byte stream from the frame packetizer into the UART transmitter.
// Valid/ready handshake; a byte moves when both are high on a clock edge.
interface frame_uart_streamer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/frame_uart_streamer.sv
// Frame packetizer: snapshots a pattern word and streams it as
// HDR, SEQ, D0..D(SIZE-1), CHK over a valid/ready byte link.
module frame_uart_streamer #(
  parameter int               WIDTH  = 8,
  parameter int               SIZE   = 16,
  parameter logic [WIDTH-1:0] HEADER = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH*SIZE-1:0] frame_in,
  frame_uart_streamer_if.master tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic [7:0]            seq_num
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    DATA,
    CHK
  } state_t;

  state_t                state, state_d;
  logic [WIDTH*SIZE-1:0] snap, snap_d;
  logic [7:0]            seq_lat, seq_lat_d;
  logic [7:0]            seq_num_d;
  logic [WIDTH-1:0]      acc, acc_d;
  logic [WIDTH-1:0]      data_d, sum;
  logic [IW-1:0]         idx, idx_d, nidx;
  logic                  valid_d, done_d, ovr_d;
  logic                  xfer;

  assign xfer = tx.tx_valid && tx.tx_ready;
  // Running sum including the byte currently on the link.
  assign sum  = acc + tx.tx_data;
  assign nidx = idx + 1'b1;

  always_comb begin
    state_d   = state;
    snap_d    = snap;
    seq_lat_d = seq_lat;
    seq_num_d = seq_num;
    acc_d     = acc;
    idx_d     = idx;
    data_d    = tx.tx_data;
    valid_d   = tx.tx_valid;
    done_d    = 1'b0;
    ovr_d     = overrun | (start && (state != IDLE));
    unique case (state)
      IDLE: begin
        if (start) begin
          snap_d    = frame_in;
          seq_lat_d = seq_num;
          acc_d     = '0;
          valid_d   = 1'b1;
          data_d    = HEADER;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          data_d  = WIDTH'(seq_lat);
          state_d = SEQ;
        end
      end
      SEQ: begin
        if (xfer) begin
          acc_d   = sum;
          idx_d   = '0;
          data_d  = snap[0 +: WIDTH];
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          acc_d = sum;
          if (idx == LAST) begin
            data_d  = '0 - sum;
            state_d = CHK;
          end else begin
            idx_d  = nidx;
            data_d = snap[nidx*WIDTH +: WIDTH];
          end
        end
      end
      CHK: begin
        if (xfer) begin
          valid_d   = 1'b0;
          done_d    = 1'b1;
          seq_num_d = seq_num + 8'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      snap        <= '0;
      seq_lat     <= '0;
      seq_num     <= '0;
      acc         <= '0;
      idx         <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      snap        <= snap_d;
      seq_lat     <= seq_lat_d;
      seq_num     <= seq_num_d;
      acc         <= acc_d;
      idx         <= idx_d;
      tx.tx_data  <= data_d;
      tx.tx_valid <= valid_d;
      frame_done  <= done_d;
      overrun     <= ovr_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Bench for frame_uart_streamer: scoreboard of expected packet bytes
// filled on each start, drained by a monitor on every transfer.
module tb_frame_uart_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] frame_in;
  logic         busy;
  logic         frame_done;
  logic         overrun;
  logic [7:0]   seq_num;

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   exp_q[$];
  logic [7:0]   exp_seq;
  logic [7:0]   prev_data;
  bit           prev_stall = 0;

  logic [7:0] pat [16] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h40, 8'hFF,
    8'hFF, 8'h40, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00
  };

  frame_uart_streamer_if #(.WIDTH(8)) tx_if ();

  frame_uart_streamer #(
    .WIDTH (8),
    .SIZE  (16),
    .HEADER(8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_in  (frame_in),
    .tx        (tx_if),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun),
    .seq_num   (seq_num)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer happens at the next posedge; inputs are stable from here on.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(tx_if.tx_valid), 1);
        check("hold_data", 32'(tx_if.tx_data), 32'(prev_data));
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        check("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check("byte", 32'(tx_if.tx_data), 32'(exp_q.pop_front()));
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
    end
  end

  task automatic load_pattern();
    for (int i = 0; i < 16; i++)
      frame_in[i*8 +: 8] = pat[i];
  endtask

  task automatic push_packet();
    logic [7:0] s;
    s = exp_seq;
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_seq);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(frame_in[i*8 +: 8]);
      s = s + frame_in[i*8 +: 8];
    end
    exp_q.push_back(8'h00 - s);
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic kick();
    push_packet();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound,
                           input bit rnd,
                           input int exp_cyc);
    int cyc;
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < bound) begin
      tx_if.tx_ready = rnd ? ($urandom_range(9) < 3) : 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("frame_done_seen", 32'(frame_done), 1);
    if (exp_cyc > 0)
      check("frame_cycles", cyc, exp_cyc);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(tx_if.tx_valid), 0);
    check("rst_data", 32'(tx_if.tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_seq", 32'(seq_num), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_seq = 8'd0;
  endtask

  initial begin
    int v;
    rst            = 1'b1;
    start          = 1'b0;
    frame_in       = '0;
    tx_if.tx_ready = 1'b0;
    exp_seq        = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: basic packet at full rate
    load_pattern();
    tx_if.tx_ready = 1'b1;
    check("t1_seq_before", 32'(seq_num), 0);
    kick();
    wait_done(100, 0, 19);
    check("t1_seq_after", 32'(seq_num), 1);
    @(posedge clk);
    #1;
    check("t1_done_pulse", 32'(frame_done), 0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_valid", 32'(tx_if.tx_valid), 0);

    // 2: second packet, seq 1
    kick();
    wait_done(100, 0, 19);
    check("t2_overrun", 32'(overrun), 0);
    check("t2_seq", 32'(seq_num), 2);

    // 3: random backpressure
    kick();
    wait_done(3000, 1, 0);
    check("t3_seq", 32'(seq_num), 3);
    tx_if.tx_ready = 1'b1;

    // 4: start and frame_in change during DATA
    kick();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    check("t4_busy", 32'(busy), 1);
    start    = 1'b1;
    frame_in = '1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_overrun", 32'(overrun), 1);
    wait_done(100, 0, 0);
    v = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (tx_if.tx_valid) v++;
    end
    check("t4_no_queue", v, 0);
    check("t4_idle", 32'(busy), 0);
    check("t4_overrun_sticky", 32'(overrun), 1);
    check("t4_seq", 32'(seq_num), 4);
    load_pattern();

    // 5: 257 back-to-back frames from seq 0
    do_reset();
    for (int f = 0; f < 257; f++) begin
      kick();
      wait_done(100, 0, 19);
    end
    check("t5_seq_wrap", 32'(seq_num), 1);
    check("t5_overrun", 32'(overrun), 0);

    // 6: async reset mid-DATA under backpressure
    kick();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    tx_if.tx_ready = 1'b0;
    @(posedge clk);
    #1;
    check("t6_stalled_valid", 32'(tx_if.tx_valid), 1);
    check("t6_stalled_busy", 32'(busy), 1);
    do_reset();
    tx_if.tx_ready = 1'b1;
    kick();
    wait_done(100, 0, 19);
    check("t6_seq", 32'(seq_num), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
